// File: rtl/traffic_ctrl_param.sv
// Parametrised two-road intersection controller with built-in tick prescaler,
// phase timer, all-red clearance, demand-driven early green cut and flash mode.
module traffic_ctrl_param #(
    parameter int TICK_DIV    = 100,
    parameter int GREEN_T     = 10,
    parameter int YELLOW_T    = 2,
    parameter int ALLRED_T    = 1,
    parameter int MIN_GREEN_T = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_ns,
    input  logic       req_es,
    input  logic       flash_mode,
    output logic [1:0] ns_light,
    output logic [1:0] es_light,
    output logic [2:0] phase
);

    localparam int MAX_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
    localparam int MAX_T  = (MAX_GY > ALLRED_T) ? MAX_GY : ALLRED_T;
    localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN_T - 1);

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;
    localparam logic [1:0] OFF    = 2'b11;

    typedef enum logic [2:0] {
        AR_TO_NS  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        AR_TO_ES  = 3'd3,
        ES_GREEN  = 3'd4,
        ES_YELLOW = 3'd5,
        FLASH     = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    logic [TW-1:0] timer;
    logic          lat_ns, lat_es, toggle;
    logic          tick, state_chg;

    assign tick      = (presc == TICK_LAST);
    assign state_chg = (state_nxt != state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= AR_TO_NS;
            presc  <= '0;
            timer  <= '0;
            lat_ns <= 1'b0;
            lat_es <= 1'b0;
            toggle <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_chg) begin
                presc <= '0;
                timer <= '0;
            end else if (tick) begin
                presc <= '0;
                // FLASH has no duration, so its timer is parked to stay bounded
                if (state != FLASH)
                    timer <= timer + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            lat_ns <= (state_nxt == NS_GREEN && state != NS_GREEN) ? 1'b0 : (lat_ns | req_ns);
            lat_es <= (state_nxt == ES_GREEN && state != ES_GREEN) ? 1'b0 : (lat_es | req_es);
            toggle <= (state == FLASH && !state_chg) ? (toggle ^ tick) : 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            AR_TO_NS:  if (tick && timer == ALLRED_LAST) state_nxt = flash_mode ? FLASH : NS_GREEN;
            NS_GREEN:  if (tick && (timer == GREEN_LAST || (lat_es && timer >= MIN_LAST)))
                           state_nxt = NS_YELLOW;
            NS_YELLOW: if (tick && timer == YELLOW_LAST) state_nxt = AR_TO_ES;
            AR_TO_ES:  if (tick && timer == ALLRED_LAST) state_nxt = flash_mode ? FLASH : ES_GREEN;
            ES_GREEN:  if (tick && (timer == GREEN_LAST || (lat_ns && timer >= MIN_LAST)))
                           state_nxt = ES_YELLOW;
            ES_YELLOW: if (tick && timer == YELLOW_LAST) state_nxt = AR_TO_NS;
            FLASH:     if (tick && !flash_mode) state_nxt = AR_TO_NS;
            default:   state_nxt = AR_TO_NS;
        endcase
    end

    always_comb begin
        ns_light = RED;
        es_light = RED;
        phase    = state;
        case (state)
            NS_GREEN:  ns_light = GREEN;
            NS_YELLOW: ns_light = YELLOW;
            ES_GREEN:  es_light = GREEN;
            ES_YELLOW: es_light = YELLOW;
            FLASH: begin
                ns_light = toggle ? OFF : YELLOW;
                es_light = toggle ? OFF : RED;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Self-checking bench: cycle-count reference model of the controller compared every cycle.
module tb_traffic_ctrl_param;

    localparam int TD  = 2;
    localparam int GT  = 10;
    localparam int YT  = 2;
    localparam int ART = 1;
    localparam int MIN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_ns = 1'b0, req_es = 1'b0, flash_mode = 1'b0;
    logic [1:0] ns_light, es_light;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    traffic_ctrl_param #(
        .TICK_DIV(TD), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(ART), .MIN_GREEN_T(MIN)
    ) dut (
        .clk(clk), .rst(rst), .req_ns(req_ns), .req_es(req_es), .flash_mode(flash_mode),
        .ns_light(ns_light), .es_light(es_light), .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model: counts cycles spent in the current phase and applies the timing rules.
    int m_state, m_cnt;
    bit m_lat_ns, m_lat_es, m_tog;

    always @(posedge clk or posedge rst) begin : model
        int cnt1, nxt;
        bit tk;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_lat_ns = 0; m_lat_es = 0; m_tog = 0;
        end else begin
            cnt1 = m_cnt + 1;
            tk   = (cnt1 % TD) == 0;
            nxt  = m_state;
            case (m_state)
                0: if (cnt1 == ART * TD) nxt = flash_mode ? 6 : 1;
                1: if (cnt1 == GT * TD || (m_lat_es && tk && cnt1 / TD >= MIN)) nxt = 2;
                2: if (cnt1 == YT * TD) nxt = 3;
                3: if (cnt1 == ART * TD) nxt = flash_mode ? 6 : 4;
                4: if (cnt1 == GT * TD || (m_lat_ns && tk && cnt1 / TD >= MIN)) nxt = 5;
                5: if (cnt1 == YT * TD) nxt = 0;
                6: if (tk && !flash_mode) nxt = 0;
                default: nxt = 0;
            endcase
            m_lat_ns = (nxt == 1 && m_state != 1) ? 1'b0 : (m_lat_ns | req_ns);
            m_lat_es = (nxt == 4 && m_state != 4) ? 1'b0 : (m_lat_es | req_es);
            if (nxt != 6 || m_state != 6) m_tog = 0;
            else if (tk) m_tog = ~m_tog;
            m_cnt   = (nxt != m_state) ? 0 : cnt1;
            m_state = nxt;
        end
    end

    function automatic logic [1:0] exp_ns(int s, bit t);
        case (s)
            1: return 2'b10;
            2: return 2'b01;
            6: return t ? 2'b11 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] exp_es(int s, bit t);
        case (s)
            4: return 2'b10;
            5: return 2'b01;
            6: return t ? 2'b11 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    // Safety monitor: never two non-red heads unless both are dark
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (ns_light != 2'b00 && es_light != 2'b00 && !(ns_light == 2'b11 && es_light == 2'b11)) begin
                errors++;
                $display("FAIL safety t=%0t ns=%b es=%b (one must be RED or both OFF)", $time, ns_light, es_light);
            end
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; req_ns = 1'b0; req_es = 1'b0; flash_mode = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ns_light !== 2'b00 || es_light !== 2'b00 || phase !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got %b/%b/%0d want 00/00/0", ns_light, es_light, phase);
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal;
        int cnt [7];
        int want [7] = '{2, 20, 4, 2, 20, 4, 0};
        for (int k = 0; k < 7; k++) cnt[k] = 0;
        do_reset();
        for (int i = 0; i < 104; i++) begin
            @(negedge clk);
            if (i < 52 && phase < 3'd7) cnt[phase]++;
            checks++;
            if (ns_light !== exp_ns(m_state, m_tog) || es_light !== exp_es(m_state, m_tog) || phase !== 3'(m_state)) begin
                errors++;
                $display("FAIL nominal t=%0t got %b/%b/%0d want %b/%b/%0d", $time, ns_light, es_light, phase,
                         exp_ns(m_state, m_tog), exp_es(m_state, m_tog), m_state);
            end
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (cnt[k] != want[k]) begin
                errors++;
                $display("FAIL nominal_duration phase %0d got %0d cycles want %0d", k, cnt[k], want[k]);
            end
        end
    endtask

    task automatic test_demand(input int at, input int want, input string name);
        int n, len;
        do_reset();
        n = 0;
        while (phase !== 3'd1 && n < 100) begin @(negedge clk); n++; end
        len = 0;
        while (phase === 3'd1 && len < 40) begin
            if (len == at) req_es = 1'b1;
            @(negedge clk);
            req_es = 1'b0;
            len++;
            checks++;
            if (ns_light !== exp_ns(m_state, m_tog) || es_light !== exp_es(m_state, m_tog) || phase !== 3'(m_state)) begin
                errors++;
                $display("FAIL %s t=%0t got %b/%b/%0d want %b/%b/%0d", name, $time, ns_light, es_light, phase,
                         exp_ns(m_state, m_tog), exp_es(m_state, m_tog), m_state);
            end
        end
        checks++;
        if (len != want) begin
            errors++;
            $display("FAIL %s_len got %0d green cycles want %0d", name, len, want);
        end
        // the consumed ES demand must not shorten the following NS green
        n = 0;
        while (phase !== 3'd1 && n < 200) begin @(negedge clk); n++; end
        len = 0;
        while (phase === 3'd1 && len < 40) begin @(negedge clk); len++; end
        checks++;
        if (len != 20) begin
            errors++;
            $display("FAIL %s_latch_clr got %0d green cycles want 20", name, len);
        end
    endtask

    task automatic test_flash;
        int n;
        do_reset();
        n = 0;
        while (phase !== 3'd4 && n < 100) begin @(negedge clk); n++; end
        flash_mode = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            checks++;
            if (ns_light !== exp_ns(m_state, m_tog) || es_light !== exp_es(m_state, m_tog) || phase !== 3'(m_state)) begin
                errors++;
                $display("FAIL flash t=%0t got %b/%b/%0d want %b/%b/%0d", $time, ns_light, es_light, phase,
                         exp_ns(m_state, m_tog), exp_es(m_state, m_tog), m_state);
            end
        end
        checks++;
        if (phase !== 3'd6) begin
            errors++;
            $display("FAIL flash_entry got phase %0d want 6", phase);
        end
        flash_mode = 1'b0;
        n = 0;
        while (phase !== 3'd0 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (ns_light !== 2'b00 || es_light !== 2'b00 || phase !== 3'd0) begin
            errors++;
            $display("FAIL flash_exit got %b/%b/%0d want 00/00/0", ns_light, es_light, phase);
        end
        n = 0;
        while (phase !== 3'd1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (ns_light !== 2'b10 || es_light !== 2'b00) begin
            errors++;
            $display("FAIL flash_resume got %b/%b want 10/00", ns_light, es_light);
        end
    endtask

    task automatic test_async_reset;
        int n;
        do_reset();
        n = 0;
        while (phase !== 3'd2 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (ns_light !== 2'b00 || es_light !== 2'b00 || phase !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got %b/%b/%0d want 00/00/0", ns_light, es_light, phase);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (ns_light !== exp_ns(m_state, m_tog) || es_light !== exp_es(m_state, m_tog) || phase !== 3'(m_state)) begin
                errors++;
                $display("FAIL after_reset t=%0t got %b/%b/%0d want %b/%b/%0d", $time, ns_light, es_light, phase,
                         exp_ns(m_state, m_tog), exp_es(m_state, m_tog), m_state);
            end
        end
    endtask

    task automatic test_random;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            checks++;
            if (ns_light !== exp_ns(m_state, m_tog) || es_light !== exp_es(m_state, m_tog) || phase !== 3'(m_state)) begin
                errors++;
                $display("FAIL random t=%0t got %b/%b/%0d want %b/%b/%0d", $time, ns_light, es_light, phase,
                         exp_ns(m_state, m_tog), exp_es(m_state, m_tog), m_state);
            end
            req_ns = ($urandom_range(0, 19) == 0);
            req_es = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) flash_mode = ~flash_mode;
        end
        flash_mode = 1'b0;
        req_ns = 1'b0;
        req_es = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_demand(2, 8, "early_cut");
        test_demand(14, 16, "late_demand");
        test_flash();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
